// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state type and default sizing shared by the UART arbiter files
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DRAIN} state_e;
  localparam int NUM_REQ_DEF = 2;
  localparam int DATA_WIDTH_DEF = 32;
endpackage

// File: rtl/uart_arbiter_if.sv
// uart_arbiter_if: requester and UART word-port signals of uart_arbiter
// UART_ARB_LOCK_EN adds the per-requester req_lock_i vector
interface uart_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [NUM_REQ-1:0] req_read_i, req_write_i, req_read_resp_o, req_write_resp_o, grant_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [DATA_WIDTH-1:0] req_rdata_o, uart_wdata_o, uart_rdata_i;
  logic uart_read_o, uart_write_o, uart_read_resp_i, uart_write_resp_i;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0] req_lock_i;
`endif
  modport slave (
`ifdef UART_ARB_LOCK_EN
    input req_lock_i,
`endif
    input req_read_i, req_write_i, req_wdata_i, uart_rdata_i, uart_read_resp_i, uart_write_resp_i,
    output req_rdata_o, req_read_resp_o, req_write_resp_o, grant_o, uart_read_o, uart_write_o,
    output uart_wdata_o
  );
  modport master (
`ifdef UART_ARB_LOCK_EN
    output req_lock_i,
`endif
    output req_read_i, req_write_i, req_wdata_i, uart_rdata_i, uart_read_resp_i, uart_write_resp_i,
    input req_rdata_o, req_read_resp_o, req_write_resp_o, grant_o, uart_read_o, uart_write_o,
    input uart_wdata_o
  );
endinterface

// File: rtl/uart_arbiter_rr.sv
// rr_arbiter: one-hot round-robin pick, searching from the index after last_i
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_o
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] idx;
  // walk farthest to nearest so the nearest pending requester wins the overwrite
  always_comb begin
    gnt_o = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = PW'((int'(last_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_arbiter.sv
// uart_arbiter: round-robin sharing of one UART word port among NUM_REQ requesters
// UART_ARB_LOCK_EN adds req_lock_i so an owner can keep the grant across transactions
module uart_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  uart_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, rd_resp_q, rd_resp_d, wr_resp_q, wr_resp_d;
  logic [NUM_REQ-1:0] pend, rr_gnt, sel;
  logic [PW-1:0] last_q, last_d, owner, sel_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_q, rd_d, lock_q, lock_d, lock_now, resp_hit;
  assign pend = bus.req_read_i | bus.req_write_i;
  assign sel = lock_q ? grant_q & pend : rr_gnt;
  assign resp_hit = rd_q ? bus.uart_read_resp_i : bus.uart_write_resp_i;
`ifdef UART_ARB_LOCK_EN
  assign lock_now = bus.req_lock_i[owner];
`else
  assign lock_now = 1'b0;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req_i(pend), .last_i(last_q), .gnt_o(rr_gnt));
  always_comb begin
    owner = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner = grant_q[i] ? PW'(i) : owner;
      sel_idx = sel[i] ? PW'(i) : sel_idx;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    rd_d = rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lock_d = lock_q;
    rd_resp_d = '0;
    wr_resp_d = '0;
    case (state_q)
      IDLE: begin
        if (lock_q && !lock_now) begin
          lock_d = 1'b0;
          grant_d = '0;
        end else if (|sel) begin
          state_d = ISSUE;
          grant_d = sel;
          rd_d = bus.req_read_i[sel_idx];
          wdata_d = bus.req_wdata_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ISSUE: state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (resp_hit) begin
          state_d = DRAIN;
          rd_resp_d = rd_q ? grant_q : '0;
          wr_resp_d = rd_q ? '0 : grant_q;
          rdata_d = rd_q ? bus.uart_rdata_i : rdata_q;
        end
      end
      DRAIN: begin
        // the UART may hold its response a second cycle; wait it out before rearbitrating
        if (!bus.uart_read_resp_i && !bus.uart_write_resp_i) begin
          state_d = IDLE;
          last_d = owner;
          lock_d = lock_now;
          grant_d = lock_now ? grant_q : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= PW'(NUM_REQ - 1);
      rd_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lock_q <= 1'b0;
      rd_resp_q <= '0;
      wr_resp_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      rd_q <= rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lock_q <= lock_d;
      rd_resp_q <= rd_resp_d;
      wr_resp_q <= wr_resp_d;
    end
  end
  assign bus.grant_o = grant_q;
  assign bus.uart_read_o = state_q == ISSUE && rd_q;
  assign bus.uart_write_o = state_q == ISSUE && !rd_q;
  assign bus.uart_wdata_o = wdata_q;
  assign bus.req_rdata_o = rdata_q;
  assign bus.req_read_resp_o = rd_resp_q;
  assign bus.req_write_resp_o = wr_resp_q;
endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter: directed bench for uart_arbiter; lock scenario only when UART_ARB_LOCK_EN is defined
module tb_uart_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  logic [1:0] g, pv;
  logic was_rd;
  logic [31:0] wd;
  int rcnt, wcnt, ovl, lat;

  uart_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(32)) bus ();
  uart_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // UART and requester model for one transaction: waits (bounded) for the command, answers it,
  // drops the served request the cycle after its response, optionally re-raises it later
  task automatic uart_txn(input int hold, input logic [31:0] rdata, input bit rearm);
    logic idx;
    g = 'x; was_rd = 1'bx; wd = 'x; rcnt = 0; wcnt = 0; pv = '0; ovl = 0; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.uart_read_o || bus.uart_write_o) && lat < 20);
    if (!(bus.uart_read_o || bus.uart_write_o)) begin
      lat = -1;
      return;
    end
    g = bus.grant_o; was_rd = bus.uart_read_o; wd = bus.uart_wdata_o;
    idx = g[1];
    @(posedge clk); #1;
    if (was_rd) bus.uart_read_resp_i = 1'b1; else bus.uart_write_resp_i = 1'b1;
    bus.uart_rdata_i = rdata;
    @(negedge clk);
    ovl += int'(bus.uart_read_o || bus.uart_write_o);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (k == hold - 1) begin
        bus.uart_read_resp_i = 1'b0;
        bus.uart_write_resp_i = 1'b0;
      end
      if (k == 1) begin
        if (was_rd) bus.req_read_i[idx] = 1'b0; else bus.req_write_i[idx] = 1'b0;
      end
      @(negedge clk);
      rcnt += int'(bus.req_read_resp_o != 2'b00);
      wcnt += int'(bus.req_write_resp_o != 2'b00);
      pv |= bus.req_read_resp_o | bus.req_write_resp_o;
      ovl += int'(bus.uart_read_o || bus.uart_write_o);
    end
    @(posedge clk); #1;
    if (rearm) begin
      if (was_rd) bus.req_read_i[idx] = 1'b1; else bus.req_write_i[idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.grant_o !== 2'b00) begin fails++; $display("FAIL reset_grant got %h exp 0", bus.grant_o); end
    checks++; if (bus.uart_read_o !== 1'b0 || bus.uart_write_o !== 1'b0) begin fails++; $display("FAIL reset_cmd got %b%b exp 00", bus.uart_read_o, bus.uart_write_o); end
    checks++; if (bus.req_read_resp_o !== 2'b00 || bus.req_write_resp_o !== 2'b00) begin fails++; $display("FAIL reset_resp got %h/%h exp 0/0", bus.req_read_resp_o, bus.req_write_resp_o); end
    checks++; if (bus.req_rdata_o !== 32'h0 || bus.uart_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_data got %h/%h exp 0/0", bus.req_rdata_o, bus.uart_wdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    bus.req_wdata_i[31:0] = 32'hA5A5_0001;
    bus.req_write_i = 2'b01;
    uart_txn(2, 32'hDEAD_DEAD, 1'b0);
    checks++; if (lat !== 2) begin fails++; $display("FAIL write_latency got %0d exp 2", lat); end
    checks++; if (g !== 2'b01 || was_rd !== 1'b0) begin fails++; $display("FAIL write_grant got %h rd=%b exp 1 rd=0", g, was_rd); end
    checks++; if (wd !== 32'hA5A5_0001) begin fails++; $display("FAIL write_wdata got %h exp a5a50001", wd); end
    checks++; if (wcnt !== 1 || rcnt !== 0 || pv !== 2'b01) begin fails++; $display("FAIL write_resp got w%0d r%0d pv=%h exp w1 r0 pv=1", wcnt, rcnt, pv); end
    checks++; if (ovl !== 0) begin fails++; $display("FAIL write_cmd_pulse got %0d extra exp 0", ovl); end
    checks++; if (bus.req_rdata_o !== 32'h0) begin fails++; $display("FAIL write_rdata got %h exp 0", bus.req_rdata_o); end
  endtask

  task automatic test_single_read();
    bus.req_read_i = 2'b10;
    uart_txn(1, 32'h1234_5678, 1'b0);
    checks++; if (g !== 2'b10 || was_rd !== 1'b1) begin fails++; $display("FAIL read_grant got %h rd=%b exp 2 rd=1", g, was_rd); end
    checks++; if (rcnt !== 1 || wcnt !== 0 || pv !== 2'b10) begin fails++; $display("FAIL read_resp got r%0d w%0d pv=%h exp r1 w0 pv=2", rcnt, wcnt, pv); end
    checks++; if (bus.req_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL read_rdata got %h exp 12345678", bus.req_rdata_o); end
    bus.uart_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL read_rdata_hold got %h exp 12345678", bus.req_rdata_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    logic [31:0] ew;
    bus.req_wdata_i = {32'hC1C1_0001, 32'hC0C0_0000};
    bus.req_write_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      uart_txn(1, 32'hFFFF_FFFF, t < 2);
      eg = (t % 2 == 1) ? 2'b10 : 2'b01;
      ew = (t % 2 == 1) ? 32'hC1C1_0001 : 32'hC0C0_0000;
      checks++; if (g !== eg || wd !== ew) begin fails++; $display("FAIL contention_grant%0d got %h/%h exp %h/%h", t, g, wd, eg, ew); end
      checks++; if (wcnt !== 1 || pv !== eg || ovl !== 0) begin fails++; $display("FAIL contention_resp%0d got w%0d pv=%h ovl=%0d exp w1 pv=%h ovl=0", t, wcnt, pv, ovl, eg); end
    end
    checks++; if (bus.req_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL contention_rdata got %h exp 12345678", bus.req_rdata_o); end
  endtask

  task automatic test_read_write_same();
    bus.req_wdata_i[31:0] = 32'hD0D0_0000;
    bus.req_read_i = 2'b01;
    bus.req_write_i = 2'b01;
    uart_txn(1, 32'hBEEF_0001, 1'b0);
    checks++; if (g !== 2'b01 || was_rd !== 1'b1 || rcnt !== 1) begin fails++; $display("FAIL rw_first got g=%h rd=%b r%0d exp g=1 rd=1 r1", g, was_rd, rcnt); end
    checks++; if (bus.req_rdata_o !== 32'hBEEF_0001) begin fails++; $display("FAIL rw_rdata got %h exp beef0001", bus.req_rdata_o); end
    uart_txn(1, 32'h0, 1'b0);
    checks++; if (g !== 2'b01 || was_rd !== 1'b0 || wcnt !== 1 || wd !== 32'hD0D0_0000) begin fails++; $display("FAIL rw_second got g=%h rd=%b w%0d wd=%h exp g=1 rd=0 w1 wd=d0d00000", g, was_rd, wcnt, wd); end
  endtask

  task automatic test_reset_mid();
    bus.req_wdata_i[63:32] = 32'h7777_0000;
    bus.req_write_i = 2'b10;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (bus.grant_o !== 2'b10) begin fails++; $display("FAIL midrst_pre_grant got %h exp 2", bus.grant_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.uart_write_resp_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.uart_write_resp_i = 1'b0;
    bus.req_write_i = 2'b00;
    @(negedge clk);
    checks++; if (bus.grant_o !== 2'b00 || bus.uart_write_o !== 1'b0 || bus.uart_read_o !== 1'b0) begin fails++; $display("FAIL midrst_idle got g=%h cmd=%b%b exp 0 00", bus.grant_o, bus.uart_read_o, bus.uart_write_o); end
    checks++; if (bus.req_write_resp_o !== 2'b00 || bus.req_read_resp_o !== 2'b00) begin fails++; $display("FAIL midrst_resp got %h/%h exp 0/0", bus.req_read_resp_o, bus.req_write_resp_o); end
    checks++; if (bus.req_rdata_o !== 32'h0 || bus.uart_wdata_o !== 32'h0) begin fails++; $display("FAIL midrst_data got %h/%h exp 0/0", bus.req_rdata_o, bus.uart_wdata_o); end
    @(negedge clk);
    checks++; if (bus.req_write_resp_o !== 2'b00 || bus.grant_o !== 2'b00) begin fails++; $display("FAIL midrst_late got resp=%h g=%h exp 0/0", bus.req_write_resp_o, bus.grant_o); end
    @(posedge clk); #1;
    bus.req_read_i = 2'b11;
    uart_txn(1, 32'h5555_0000, 1'b0);
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL midrst_pointer got %h exp 1", g); end
    uart_txn(1, 32'h5555_0001, 1'b0);
    checks++; if (g !== 2'b10 || bus.req_rdata_o !== 32'h5555_0001) begin fails++; $display("FAIL midrst_next got g=%h rdata=%h exp 2 55550001", g, bus.req_rdata_o); end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    bus.req_wdata_i = {32'hE1E1_0001, 32'hE0E0_0000};
    bus.req_lock_i = 2'b01;
    bus.req_write_i = 2'b11;
    for (int t = 0; t < 3; t++) begin
      uart_txn(1, 32'h0, t < 2);
      checks++; if (g !== 2'b01 || wd !== 32'hE0E0_0000) begin fails++; $display("FAIL lock_hold%0d got %h/%h exp 1/e0e00000", t, g, wd); end
    end
    @(negedge clk);
    checks++; if (bus.grant_o !== 2'b01) begin fails++; $display("FAIL lock_idle_grant got %h exp 1", bus.grant_o); end
    @(posedge clk); #1;
    bus.req_lock_i = 2'b00;
    uart_txn(1, 32'h0, 1'b0);
    checks++; if (g !== 2'b10 || wd !== 32'hE1E1_0001) begin fails++; $display("FAIL lock_release got %h/%h exp 2/e1e10001", g, wd); end
  endtask
`endif

  initial begin
    bus.req_read_i = '0;
    bus.req_write_i = '0;
    bus.req_wdata_i = '0;
    bus.uart_rdata_i = '0;
    bus.uart_read_resp_i = 1'b0;
    bus.uart_write_resp_i = 1'b0;
`ifdef UART_ARB_LOCK_EN
    bus.req_lock_i = '0;
`endif
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_read_write_same();
    test_reset_mid();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the transfer word.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_read_i  input  NUM_REQ  per-requester read request, level, held until response.
REQ-006 SHALL have port req_write_i  input  NUM_REQ  per-requester write request, level, held until response.
REQ-007 SHALL have port req_wdata_i  input  NUM_REQ*DATA_WIDTH  per-requester write word; slice i belongs to requester i.
REQ-008 SHALL have port req_rdata_o  output  DATA_WIDTH  last completed read word, broadcast to all requesters.
REQ-009 SHALL have port req_read_resp_o  output  NUM_REQ  one-cycle read completion pulse to the owner.
REQ-010 SHALL have port req_write_resp_o  output  NUM_REQ  one-cycle write completion pulse to the owner.
REQ-011 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-012 SHALL have port uart_read_o / uart_write_o  output  1 each  one-cycle command pulse to the shared UART word port.
REQ-013 SHALL have port uart_wdata_o  output  DATA_WIDTH  write word to the UART.
REQ-014 SHALL have port uart_rdata_i  input  DATA_WIDTH  read word from the UART.
REQ-015 SHALL have port uart_read_resp_i / uart_write_resp_i  input  1 each  UART completion; may stay high for up to 2 consecutive cycles.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_RESP -> DRAIN -> IDLE.
REQ-017 IDLE: with any request pending, SHALL choose the owner round-robin, starting the search at the index after the last owner; after reset the search starts at index 0; grant_o is set on the transition to ISSUE.
REQ-018 If the chosen owner asserts both read and write, SHALL serve the read first; the write stays pending for a later arbitration.
REQ-019 ISSUE: SHALL drive exactly one cycle of uart_read_o or uart_write_o, then go to WAIT_RESP.
REQ-020 SHALL register uart_wdata_o from the owner's slice at grant and hold it stable until DRAIN exits.
REQ-021 WAIT_RESP: on the first cycle the matching uart_*_resp_i is high, SHALL pulse the owner's req_*_resp_o for exactly one cycle (next cycle), SHALL capture uart_rdata_i into req_rdata_o for reads, and SHALL go to DRAIN.
REQ-022 DRAIN: SHALL remain until both uart_*_resp_i are low, then return to IDLE, clear grant_o and record the owner as last owner.
REQ-023 SHALL ignore requests in ISSUE, WAIT_RESP and DRAIN; a requester drops its request in the cycle after its response.
REQ-024 SHALL hold req_rdata_o until the next read completion; write completions do not alter it.
REQ-025 SHALL have no timeout; WAIT_RESP persists until a UART response arrives.
REQ-026 Minimum transaction latency: request seen in IDLE at cycle N -> UART command at N+1; requester response 1 cycle after the first UART response cycle.

Reset
REQ-027 SHALL enter IDLE on rst, with grant_o, uart_read_o, uart_write_o, req_read_resp_o and req_write_resp_o all 0, req_rdata_o and uart_wdata_o 0, and the last-owner pointer set so index 0 is searched first.
REQ-028 Reset asserted mid-transaction SHALL abort it with no response pulse; the UART is reset on the same rst.

Configuration
REQ-029 With macro UART_ARB_LOCK_EN defined, SHALL add port req_lock_i, input, NUM_REQ wide; if the owner's lock bit is high when DRAIN exits, SHALL keep the grant and return to IDLE, serving only that owner until its lock drops.
REQ-030 Without UART_ARB_LOCK_EN, the req_lock_i port SHALL be absent and arbitration is strict round-robin per transaction.

Structure
REQ-031 SHALL place the FSM state enum typedef and the default parameter constants in package uart_arb_pkg.
REQ-032 SHALL implement the owner selection as sub-module rr_arbiter: inputs are the request vector and the last-owner pointer; the output is a one-hot grant.

Verification
REQ-033 Single write: req_write_i[0]=1, wdata 32'hA5A5_0001, UART write_resp held 2 cycles -> one uart_write_o pulse, uart_wdata_o=32'hA5A5_0001, one req_write_resp_o[0] pulse.
REQ-034 Single read: req_read_i[1]=1, uart_rdata_i=32'h1234_5678 -> req_read_resp_o[1] pulsed once, req_rdata_o=32'h1234_5678 held afterward.
REQ-035 Contention: both requesters issue back-to-back writes for 4 transactions -> grant order 0,1,0,1; no UART command overlaps a response.
REQ-036 Read+write from the same requester: both asserted on requester 0 -> read served first, then the write in a later grant.
REQ-037 Reset in WAIT_RESP: rst for 1 cycle -> FSM in IDLE, no response pulse, all outputs 0.
REQ-038 With UART_ARB_LOCK_EN: requester 0 locked for 3 writes while requester 1 requests -> requester 1 granted only after the lock drops.
